// File: rtl/mem_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
package mem_pkg;

  // Default number of 16-bit words in one cache block.
  localparam int BLOCK_WORDS_DEF = 8;

  // Arbiter transaction states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_FILL  = 3'd1,
    D_FILL  = 3'd2,
    D_WRITE = 3'd3,
    DONE    = 3'd4
  } arb_state_e;

  // Identifies which cache owns the current transaction.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // True for the states that stream block reads.
  function automatic logic is_fill(input arb_state_e s);
    return (s == I_FILL) || (s == D_FILL);
  endfunction

endpackage

// File: rtl/mem_arb_counter.sv
// Loadable counter: clear has priority over increment.
module mem_arb_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise optional +1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (D over I) arbiter sharing one pipelined 16-bit memory
// between an I-cache fill port and a D-cache fill / write-through port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              fill_valid,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [15:0]       fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid
);

  // Counters are one bit wider than the word index so "all issued" is
  // representable without a separate flag.
  localparam int             CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] BW_C   = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BLOCK_WORDS - 1);

  arb_state_e        state_q, state_d;
  req_id_e           owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic              issue_clr, issue_inc, ret_clr, ret_inc;

  mem_arb_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (issue_clr),
    .inc_i (issue_inc),
    .cnt_o (issue_cnt)
  );

  mem_arb_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ret_clr),
    .inc_i (ret_inc),
    .cnt_o (ret_cnt)
  );

  // State, owner and latched request address. d_we is not stored
  // separately: it is captured by choosing D_WRITE vs D_FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= REQ_I;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and all outputs; everything defaults low/zero.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    issue_clr  = 1'b0;
    issue_inc  = 1'b0;
    ret_clr    = 1'b0;
    ret_inc    = 1'b0;
    fill_valid = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Grant covers the whole transaction, DONE cycle included.
    i_grant = (state_q != IDLE) && (owner_q == REQ_I);
    d_grant = (state_q != IDLE) && (owner_q == REQ_D);

    case (state_q)
      IDLE: begin
        issue_clr = 1'b1;
        ret_clr   = 1'b1;
        if (d_req) begin
          owner_d = REQ_D;
          addr_d  = d_addr;
          state_d = d_we ? D_WRITE : D_FILL;
        end else if (i_req) begin
          owner_d = REQ_I;
          addr_d  = i_addr;
          state_d = I_FILL;
        end
      end

      I_FILL, D_FILL: begin
        // Back-to-back issue of every word in the block, then go quiet
        // while the remaining returns drain.
        if (issue_cnt != BW_C) begin
          mem_en    = 1'b1;
          mem_addr  = {addr_q[ADDR_W-1:IDX_W+1], issue_cnt[IDX_W-1:0], 1'b0};
          issue_inc = 1'b1;
        end
        // Returns arrive in issue order, so ret_cnt is the word index.
        if (mem_valid && is_fill(state_q)) begin
          fill_valid = 1'b1;
          fill_idx   = ret_cnt[IDX_W-1:0];
          fill_data  = mem_rdata;
          ret_inc    = 1'b1;
          if (ret_cnt == LAST_C) state_d = DONE;
        end
      end

      D_WRITE: begin
        // Single word write-through, word aligned.
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
        mem_wdata = d_wdata;
        state_d   = DONE;
      end

      DONE: begin
        i_done    = (owner_q == REQ_I);
        d_done    = (owner_q == REQ_D);
        issue_clr = 1'b1;
        ret_clr   = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_W, 16: byte-address width.
- REQ-002 SHALL have parameter BLOCK_WORDS, 8: 16-bit words per cache block (power of two).
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port i_req, input, 1: I-cache miss fill request, held until i_done.
- REQ-006 SHALL have port i_addr, input, ADDR_W: I-fill miss address.
- REQ-007 SHALL have port d_req, input, 1: D-cache request, held until d_done.
- REQ-008 SHALL have port d_we, input, 1: 1 = single-word write-through, 0 = block fill.
- REQ-009 SHALL have port d_addr, input, ADDR_W: D request address.
- REQ-010 SHALL have port d_wdata, input, 16: D write data.
- REQ-011 SHALL have port i_grant / d_grant, output, 1 each: owner of memory for the current transaction.
- REQ-012 SHALL have port fill_valid, output, 1: fill_data is a returned block word for the granted requester.
- REQ-013 SHALL have port fill_idx, output, log2(BLOCK_WORDS): word index within block of fill_data.
- REQ-014 SHALL have port fill_data, output, 16: returned word (mem_rdata pass-through).
- REQ-015 SHALL have port i_done / d_done, output, 1 each: one-cycle pulse, transaction complete.
- REQ-016 SHALL have port mem_en, mem_wr, output, 1 each: memory enable and write strobe.
- REQ-017 SHALL have port mem_addr, output, ADDR_W; mem_wdata, output, 16: memory address and write data.
- REQ-018 SHALL have port mem_rdata, input, 16; mem_valid, input, 1: pipelined memory read return, fixed unknown latency, in issue order.

Function
- REQ-019 SHALL implement FSM states IDLE, I_FILL, D_FILL, D_WRITE, DONE.
- REQ-020 SHALL in IDLE with d_req=1 go to D_WRITE (d_we=1) or D_FILL (d_we=0), else with i_req=1 go to I_FILL; D has fixed priority over I.
- REQ-021 SHALL assert the owner's grant from the cycle after the IDLE decision until the DONE cycle inclusive; at most one grant high.
- REQ-022 SHALL latch address and d_we at acceptance; later changes to req/addr/we during a transaction are ignored.
- REQ-023 SHALL in fill states issue BLOCK_WORDS reads on consecutive cycles: mem_en=1, mem_wr=0, mem_addr={addr[ADDR_W-1:4], issue_cnt, 1'b0}, issue_cnt 0..BLOCK_WORDS-1.
- REQ-024 SHALL hold mem_en=0 after the last issue while awaiting returns.
- REQ-025 SHALL on each mem_valid in a fill state assert fill_valid, fill_idx=ret_cnt, fill_data=mem_rdata, then increment ret_cnt.
- REQ-026 SHALL go to DONE on the cycle the BLOCK_WORDS-th mem_valid arrives.
- REQ-027 SHALL in D_WRITE drive mem_en=1, mem_wr=1, latched address with bit 0 forced 0, mem_wdata=d_wdata, for exactly one cycle, then go to DONE.
- REQ-028 SHALL in DONE pulse the owner's done for one cycle, clear counters, return to IDLE; the next request is evaluated in IDLE, giving at least one idle cycle between transactions.
- REQ-029 SHALL ignore mem_valid in IDLE, D_WRITE, DONE (fill_valid=0).
- REQ-030 SHALL hold mem_en, mem_wr, fill_valid, grants and dones at 0 whenever not specified high.

Reset
- REQ-031 SHALL on rst=1 at a clock edge enter IDLE with issue_cnt=ret_cnt=0 and all outputs 0 (mem_addr, mem_wdata, fill_idx = 0) from the next cycle, including mid-transaction; no done pulse for an aborted transaction.
- REQ-032 SHALL discard stale mem_valid arriving after a mid-transaction reset.

Structure
- REQ-033 SHALL place BLOCK_WORDS default, state enum, and requester-ID typedef in shared package mem_pkg.
- REQ-034 SHALL use one sub-module, mem_arb_counter (loadable clear/increment counter), instantiated for issue_cnt and ret_cnt.

Verification
- REQ-035 SHALL cover I-fill alone: i_req, i_addr=0x1234, latency 4 -> addresses 0x1230..0x123E in 8 cycles, 8 fill_valid with fill_idx 0..7, one i_done.
- REQ-036 SHALL cover simultaneous i_req and d_req (fill) in IDLE -> D served first, d_done, one idle cycle, then I_FILL, i_done.
- REQ-037 SHALL cover a D write: d_we=1, d_addr=0x0041, d_wdata=0xBEEF -> one cycle mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_done next cycle.
- REQ-038 SHALL cover rst=1 during I_FILL after 3 returns -> IDLE next cycle, outputs 0, no i_done, late mem_valid ignored.
- REQ-039 SHALL cover d_req arriving mid I_FILL -> I fill completes uninterrupted, then D is granted.
